// File: rtl/conv_window_addr_gen_if.sv
// Beat interface between the window address generator and its consumer.
// Carries the scan request/abort controls, the valid/ready beat handshake,
// the read address, the output pixel coordinates, window flags and status.
//   master : generator side (drives beats and status, receives controls)
//   slave  : consumer side (drives controls and out_ready)
interface conv_window_addr_gen_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COORD_W = 10
);
    logic               start;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  addr;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               win_first;
    logic               win_last;
    logic               scan_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, clr, out_ready,
        output out_valid, addr, out_row, out_col,
               win_first, win_last, scan_last, busy, done
    );

    modport slave (
        output start, clr, out_ready,
        input  out_valid, addr, out_row, out_col,
               win_first, win_last, scan_last, busy, done
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Convolution/pooling window address generator.
// Walks every output pixel (oy, ox) and, within it, every channel c and
// kernel tap (ky, kx), emitting one linear feature-map read address per beat.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : master side of conv_window_addr_gen_if (start/clr/out_ready in;
//         out_valid/addr/out_row/out_col/win_first/win_last/scan_last/
//         busy/done out, all registered)
module conv_window_addr_gen #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned K       = 3,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned CH      = 1,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COORD_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_window_addr_gen_if.master bus
);
    localparam int unsigned OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int unsigned OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int unsigned KW    = 4;
    localparam int unsigned CW    = 7;

    localparam logic [ADDR_W-1:0] KY_STEP   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] CHAN_STEP = ADDR_W'(IMG_W * IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]       c_q, c_d;
    logic [COORD_W-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0]   ky_off_q, ky_off_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   col_base_q, col_base_d;
    logic [ADDR_W-1:0]   chan_base_q, chan_base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wf_q, wf_d, wl_q, wl_d, sl_q, sl_d;
    logic                load;
    logic                last_tap;

    // State, loop counters, running bases and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kx_q        <= '0;
            ky_q        <= '0;
            c_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            ky_off_q    <= '0;
            row_base_q  <= '0;
            col_base_q  <= '0;
            chan_base_q <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wf_q        <= 1'b0;
            wl_q        <= 1'b0;
            sl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            c_q         <= c_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            ky_off_q    <= ky_off_d;
            row_base_q  <= row_base_d;
            col_base_q  <= col_base_d;
            chan_base_q <= chan_base_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wf_q        <= wf_d;
            wl_q        <= wl_d;
            sl_q        <= sl_d;
        end
    end

    // Next state, loop-nest advance (kx, ky, c, ox, oy) and next outputs.
    always_comb begin
        state_d     = state_q;
        kx_d        = kx_q;
        ky_d        = ky_q;
        c_d         = c_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        ky_off_d    = ky_off_q;
        row_base_d  = row_base_q;
        col_base_d  = col_base_q;
        chan_base_d = chan_base_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wf_d        = wf_q;
        wl_d        = wl_q;
        sl_d        = sl_q;
        load        = 1'b0;
        last_tap    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    kx_d        = '0;
                    ky_d        = '0;
                    c_d         = '0;
                    ox_d        = '0;
                    oy_d        = '0;
                    ky_off_d    = '0;
                    row_base_d  = '0;
                    col_base_d  = '0;
                    chan_base_d = '0;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    load        = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    if (sl_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        wf_d    = 1'b0;
                        wl_d    = 1'b0;
                        sl_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        load = 1'b1;
                        if (kx_q != KW'(K - 1)) begin
                            kx_d = kx_q + KW'(1);
                        end else begin
                            kx_d = '0;
                            if (ky_q != KW'(K - 1)) begin
                                ky_d     = ky_q + KW'(1);
                                ky_off_d = ky_off_q + KY_STEP;
                            end else begin
                                ky_d     = '0;
                                ky_off_d = '0;
                                if (c_q != CW'(CH - 1)) begin
                                    c_d         = c_q + CW'(1);
                                    chan_base_d = chan_base_q + CHAN_STEP;
                                end else begin
                                    c_d         = '0;
                                    chan_base_d = '0;
                                    if (ox_q != COORD_W'(OUT_W - 1)) begin
                                        ox_d       = ox_q + COORD_W'(1);
                                        col_base_d = col_base_q + COL_STEP;
                                    end else begin
                                        ox_d       = '0;
                                        col_base_d = '0;
                                        oy_d       = oy_q + COORD_W'(1);
                                        row_base_d = row_base_q + ROW_STEP;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address and flags are formed from the post-advance counters so they
        // land in the output registers together with the new coordinates.
        if (load) begin
            addr_d   = chan_base_d + row_base_d + ky_off_d + col_base_d
                     + ADDR_W'(kx_d);
            last_tap = (kx_d == KW'(K - 1)) && (ky_d == KW'(K - 1))
                    && (c_d == CW'(CH - 1));
            wf_d     = (kx_d == '0) && (ky_d == '0) && (c_d == '0);
            wl_d     = last_tap;
            sl_d     = last_tap && (ox_d == COORD_W'(OUT_W - 1))
                    && (oy_d == COORD_W'(OUT_H - 1));
        end

        // Abort wins over start and over beat acceptance.
        if (bus.clr) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            wf_d    = 1'b0;
            wl_d    = 1'b0;
            sl_d    = 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.addr      = addr_q;
    assign bus.out_row   = oy_q;
    assign bus.out_col   = ox_q;
    assign bus.win_first = wf_q;
    assign bus.win_last  = wl_q;
    assign bus.scan_last = sl_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: three parameter sets
// (28x28 K3 S1, 26x26 K2 S2 pool, 4x4 K3 S1 CH2) share one stimulus thread.
module tb_conv_window_addr_gen;
    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        done;
        logic [15:0] addr;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        wf;
        logic        wl;
        logic        sl;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic ready = 1'b1;
    int   sel = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    beat_t obs;
    beat_t q[$];

    always #5 clk = ~clk;

    conv_window_addr_gen_if #(.ADDR_W(16), .COORD_W(10)) b0 ();
    conv_window_addr_gen_if #(.ADDR_W(16), .COORD_W(10)) b1 ();
    conv_window_addr_gen_if #(.ADDR_W(16), .COORD_W(10)) b2 ();

    conv_window_addr_gen #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(1), .CH(1),
                           .ADDR_W(16), .COORD_W(10))
        u_dflt (.clk(clk), .rst(rst), .bus(b0));
    conv_window_addr_gen #(.IMG_W(26), .IMG_H(26), .K(2), .STRIDE(2), .CH(1),
                           .ADDR_W(16), .COORD_W(10))
        u_pool (.clk(clk), .rst(rst), .bus(b1));
    conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .CH(2),
                           .ADDR_W(16), .COORD_W(10))
        u_mc (.clk(clk), .rst(rst), .bus(b2));

    assign b0.start = start && (sel == 0);
    assign b1.start = start && (sel == 1);
    assign b2.start = start && (sel == 2);
    assign b0.clr = clr;
    assign b1.clr = clr;
    assign b2.clr = clr;
    assign b0.out_ready = ready;
    assign b1.out_ready = ready;
    assign b2.out_ready = ready;

    always_comb begin
        case (sel)
            1:       obs = {b1.out_valid, b1.busy, b1.done, b1.addr, b1.out_row,
                            b1.out_col, b1.win_first, b1.win_last, b1.scan_last};
            2:       obs = {b2.out_valid, b2.busy, b2.done, b2.addr, b2.out_row,
                            b2.out_col, b2.win_first, b2.win_last, b2.scan_last};
            default: obs = {b0.out_valid, b0.busy, b0.done, b0.addr, b0.out_row,
                            b0.out_col, b0.win_first, b0.win_last, b0.scan_last};
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic fail_now(input string tag);
        n_chk++;
        $error("FAIL %s observed=none expected=event", tag);
    endtask

    // Reference model: direct nested loops with full multiplications.
    task automatic push_expected(input int s);
        int iw, ih, k, st, ch, ow, oh;
        beat_t b;
        case (s)
            1:       begin iw = 26; ih = 26; k = 2; st = 2; ch = 1; end
            2:       begin iw = 4;  ih = 4;  k = 3; st = 1; ch = 2; end
            default: begin iw = 28; ih = 28; k = 3; st = 1; ch = 1; end
        endcase
        ow = (iw - k) / st + 1;
        oh = (ih - k) / st + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < ch; c++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            b.valid = 1'b1;
                            b.busy  = 1'b1;
                            b.done  = 1'b0;
                            b.addr  = 16'(c * iw * ih + (oy * st + ky) * iw + ox * st + kx);
                            b.row   = 10'(oy);
                            b.col   = 10'(ox);
                            b.wf    = (c == 0) && (ky == 0) && (kx == 0);
                            b.wl    = (c == ch - 1) && (ky == k - 1) && (kx == k - 1);
                            b.sl    = b.wl && (oy == oh - 1) && (ox == ow - 1);
                            q.push_back(b);
                        end
    endtask

    // One scan on DUT s with optional stall, start-while-busy, clr and rst events.
    task automatic run_scan(input int s, input int stall_at, input int start_at,
                            input int clr_at, input int rst_at,
                            input int n_exp, input int last_exp);
        int beats = 0;
        int stall = 0;
        int cyc = 0;
        bit fin = 1'b0;
        logic [15:0] last_addr = '0;
        sel = s;
        q.delete();
        push_expected(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            cyc++;
            ready = !(beats == stall_at && stall < 3);
            if (!ready) stall++;
            start = (beats == start_at);
            clr   = (beats == clr_at);
            if (q.size() == 0) begin
                fail_now($sformatf("sb_empty s%0d b%0d", s, beats));
                fin = 1'b1;
            end else begin
                chk($sformatf("beat s%0d b%0d", s, beats), 64'(obs), 64'(q[0]));
                if (ready && !clr) begin
                    void'(q.pop_front());
                    last_addr = obs.addr;
                    beats++;
                    if (obs.sl) fin = 1'b1;
                end
            end
            if (clr) fin = 1'b1;
            if (beats == rst_at) begin
                #2 rst = 1'b1;
                #1 chk($sformatf("rst_async s%0d", s), 64'(obs), 64'(0));
                fin = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        clr   = 1'b0;
        ready = 1'b1;
        if (!fin) begin
            fail_now($sformatf("timeout s%0d", s));
        end else if (rst_at >= 0) begin
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk($sformatf("idle_after_rst s%0d", s), 64'(obs), 64'(0));
            end
        end else if (clr_at >= 0) begin
            chk($sformatf("clr_stop s%0d", s), 64'({obs.valid, obs.busy, obs.done}), 64'(3'b000));
            repeat (3) begin
                @(negedge clk);
                chk($sformatf("clr_no_done s%0d", s), 64'({obs.valid, obs.busy, obs.done}), 64'(3'b000));
            end
        end else begin
            chk($sformatf("done_pulse s%0d", s), 64'({obs.valid, obs.busy, obs.done}), 64'(3'b001));
            @(negedge clk);
            chk($sformatf("done_once s%0d", s), 64'({obs.valid, obs.busy, obs.done}), 64'(3'b000));
            chk($sformatf("beat_count s%0d", s), 64'(beats), 64'(n_exp));
            chk($sformatf("last_addr s%0d", s), 64'(last_addr), 64'(last_exp));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 chk($sformatf("reset_state s%0d", s), 64'(obs), 64'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        run_scan(0, 4, 200, -1, -1, 6084, 783);
        run_scan(1, -1, -1, -1, -1, 676, 675);
        run_scan(2, -1, -1, -1, -1, 72, 31);
        run_scan(0, -1, -1, 100, -1, 0, 0);
        run_scan(0, 7, -1, 20, -1, 0, 0);
        run_scan(0, -1, -1, -1, 50, 0, 0);
        run_scan(1, 10, 30, -1, -1, 676, 675);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
